// File: rtl/line_enc_multi.sv
// Word-parallel line encoder: accepts WIDTH-bit words over valid/ready and
// serialises them one bit per clock as 2-bit line symbols in CMI,
// Manchester, differential Manchester or NRZ. CMI alternation and
// differential-Manchester line level persist across words and idle time.
module line_enc_multi #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          INIT_POL  = 1'b0
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic [1:0]       mode_sig,
  input  logic [WIDTH-1:0] data_sig,
  input  logic             data_valid_sig,
  output logic             data_ready_sig,
  output logic [1:0]       encode_sig,
  output logic             encode_valid_sig,
  output logic             busy_sig,
  output logic [15:0]      word_cnt_sig
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [1:0]       mode_q_reg;
  logic             cmi_flag_reg;
  logic             dm_level_reg;
  logic [1:0]       encode_reg;
  logic             encode_valid_reg;
  logic             busy_reg;
  logic [15:0]      word_cnt_reg;

  // Incoming word rearranged so the first bit to send is always the MSB;
  // the shifter then only ever moves left.
  logic [WIDTH-1:0] ser_in;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign ser_in[gi] = data_sig[gi];
      end else begin : g_lsb
        assign ser_in[gi] = data_sig[WIDTH-1-gi];
      end
    end
  endgenerate

  logic       last_bit;
  logic       accept;
  logic       emit;
  logic       cur_bit;
  logic [1:0] cur_mode;
  logic [1:0] sym_next;
  logic       cmi_next;
  logic       dm_next;
  logic       dm_a;

  assign last_bit       = (bit_cnt_reg == LAST_IDX);
  assign data_ready_sig = !reset_sig && ((state_reg == IDLE) || ((state_reg == SHIFT) && last_bit));
  assign accept         = data_valid_sig && data_ready_sig;
  // A symbol is produced on every edge that either starts a word or continues one.
  assign emit           = accept || ((state_reg == SHIFT) && !last_bit);
  // On an accept edge the first bit comes straight from the input word.
  assign cur_bit        = accept ? ser_in[WIDTH-1] : shift_reg[WIDTH-1];
  assign cur_mode       = accept ? mode_sig : mode_q_reg;

  // Symbol and polarity-state lookahead for the bit about to be emitted.
  always_comb begin
    sym_next = 2'b01;
    cmi_next = cmi_flag_reg;
    dm_next  = dm_level_reg;
    dm_a     = 1'b0;
    case (cur_mode)
      2'd0: begin
        if (cur_bit) begin
          sym_next = {~cmi_flag_reg, ~cmi_flag_reg};
          cmi_next = ~cmi_flag_reg;
        end else begin
          sym_next = 2'b01;
        end
      end
      2'd1: sym_next = cur_bit ? 2'b10 : 2'b01;
      2'd2: begin
        dm_a     = cur_bit ? dm_level_reg : ~dm_level_reg;
        sym_next = {dm_a, ~dm_a};
        dm_next  = ~dm_a;
      end
      default: sym_next = {cur_bit, cur_bit};
    endcase
  end

  // Word acceptance, serialisation and registered symbol output.
  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      mode_q_reg       <= 2'd0;
      cmi_flag_reg     <= INIT_POL;
      dm_level_reg     <= INIT_POL;
      encode_reg       <= 2'b01;
      encode_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      word_cnt_reg     <= 16'd0;
    end else if (emit) begin
      state_reg        <= SHIFT;
      encode_reg       <= sym_next;
      encode_valid_reg <= 1'b1;
      busy_reg         <= 1'b1;
      cmi_flag_reg     <= cmi_next;
      dm_level_reg     <= dm_next;
      if (accept) begin
        shift_reg    <= ser_in << 1;
        bit_cnt_reg  <= '0;
        mode_q_reg   <= mode_sig;
        word_cnt_reg <= word_cnt_reg + 16'd1;
      end else begin
        shift_reg    <= shift_reg << 1;
        bit_cnt_reg  <= bit_cnt_reg + CW'(1);
      end
    end else if (state_reg == SHIFT) begin
      state_reg        <= IDLE;
      encode_reg       <= 2'b01;
      encode_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end
  end

  assign encode_sig       = encode_reg;
  assign encode_valid_sig = encode_valid_reg;
  assign busy_sig         = busy_reg;
  assign word_cnt_sig     = word_cnt_reg;

endmodule

// File: tb/tb_line_enc_multi.sv
// Directed bench for line_enc_multi: main 8-bit MSB-first build, an LSB-first
// build and a 1-bit build with INIT_POL=1. Expected symbols are hand-derived.
module tb_line_enc_multi;

  logic clk_sig = 1'b0;
  always #5 clk_sig = ~clk_sig;

  int checks = 0;
  int failures = 0;

  // main build: WIDTH=8, MSB_FIRST=1, INIT_POL=0
  logic       rst, dv, rdy, ev, busy;
  logic [1:0] mode, enc;
  logic [7:0] data;
  logic [15:0] wc;

  // LSB-first build
  logic       rst1, dv1, rdy1, ev1, busy1;
  logic [1:0] mode1, enc1;
  logic [7:0] data1;
  logic [15:0] wc1;

  // one-bit build, INIT_POL=1
  logic       rst2, dv2, rdy2, ev2, busy2;
  logic [1:0] mode2, enc2;
  logic [0:0] data2;
  logic [15:0] wc2;

  line_enc_multi #(.WIDTH(8), .MSB_FIRST(1'b1), .INIT_POL(1'b0)) u0 (
    .clk_sig(clk_sig), .reset_sig(rst), .mode_sig(mode), .data_sig(data),
    .data_valid_sig(dv), .data_ready_sig(rdy), .encode_sig(enc),
    .encode_valid_sig(ev), .busy_sig(busy), .word_cnt_sig(wc));

  line_enc_multi #(.WIDTH(8), .MSB_FIRST(1'b0), .INIT_POL(1'b0)) u1 (
    .clk_sig(clk_sig), .reset_sig(rst1), .mode_sig(mode1), .data_sig(data1),
    .data_valid_sig(dv1), .data_ready_sig(rdy1), .encode_sig(enc1),
    .encode_valid_sig(ev1), .busy_sig(busy1), .word_cnt_sig(wc1));

  line_enc_multi #(.WIDTH(1), .MSB_FIRST(1'b1), .INIT_POL(1'b1)) u2 (
    .clk_sig(clk_sig), .reset_sig(rst2), .mode_sig(mode2), .data_sig(data2),
    .data_valid_sig(dv2), .data_ready_sig(rdy2), .encode_sig(enc2),
    .encode_valid_sig(ev2), .busy_sig(busy2), .word_cnt_sig(wc2));

  task automatic tick();
    @(posedge clk_sig);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; dv = 1'b0; mode = 2'd0; data = 8'h00;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dv = 1'b0;
    tick(); tick();
    checks++; if (enc !== 2'b01) begin failures++; $display("FAIL reset_enc got=%b exp=01", enc); end
    checks++; if (ev !== 1'b0) begin failures++; $display("FAIL reset_ev got=%b exp=0", ev); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wc !== 16'd0) begin failures++; $display("FAIL reset_wc got=%0d exp=0", wc); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rdy); end
    rst = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", rdy); end
    $display("reset: enc=%b ev=%b wc=%0d", enc, ev, wc);
  endtask

  task automatic test_cmi();
    logic [1:0] exp_s [8] = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01};
    do_reset();
    dv = 1'b1; data = 8'hB4; mode = 2'd0;
    tick();
    dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      $display("cmi B4 sym%0d enc=%b ev=%b", i, enc, ev);
      checks++; if (enc !== exp_s[i]) begin failures++; $display("FAIL cmi_sym%0d got=%b exp=%b", i, enc, exp_s[i]); end
      checks++; if (ev !== 1'b1) begin failures++; $display("FAIL cmi_ev%0d got=%b exp=1", i, ev); end
      tick();
    end
    checks++; if (ev !== 1'b0) begin failures++; $display("FAIL cmi_idle_ev got=%b exp=0", ev); end
    // four ones in B4 leave the flag back at 0
    dv = 1'b1; data = 8'h80;
    tick();
    dv = 1'b0;
    $display("cmi 80 sym0 enc=%b", enc);
    checks++; if (enc !== 2'b11) begin failures++; $display("FAIL cmi_80_first got=%b exp=11", enc); end
    repeat (8) tick();
  endtask

  task automatic test_manchester();
    logic [1:0] exp_s [8] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    dv = 1'b1; data = 8'hA5; mode = 2'd1;
    tick();
    dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      $display("man A5 sym%0d enc=%b busy=%b", i, enc, busy);
      checks++; if (enc !== exp_s[i]) begin failures++; $display("FAIL man_sym%0d got=%b exp=%b", i, enc, exp_s[i]); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL man_busy%0d got=%b exp=1", i, busy); end
      tick();
    end
    checks++; if (enc !== 2'b01) begin failures++; $display("FAIL man_idle_enc got=%b exp=01", enc); end
    checks++; if (ev !== 1'b0) begin failures++; $display("FAIL man_idle_ev got=%b exp=0", ev); end
    checks++; if (wc !== 16'd1) begin failures++; $display("FAIL man_wc got=%0d exp=1", wc); end
  endtask

  task automatic test_diff_manchester();
    logic [1:0] exp_s [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    dv = 1'b1; data = 8'h0F; mode = 2'd2;
    tick();
    dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      $display("dm 0F sym%0d enc=%b", i, enc);
      checks++; if (enc !== exp_s[i]) begin failures++; $display("FAIL dm_sym%0d got=%b exp=%b", i, enc, exp_s[i]); end
      tick();
    end
    // last symbol 10 means a=1, so level = ~a = 0: a leading one now gives 01
    dv = 1'b1; data = 8'h80;
    tick();
    dv = 1'b0;
    $display("dm 80 sym0 enc=%b", enc);
    checks++; if (enc !== 2'b01) begin failures++; $display("FAIL dm_level_carry got=%b exp=01", enc); end
    repeat (8) tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_s [16] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    do_reset();
    dv = 1'b1; data = 8'hFF; mode = 2'd0;
    #1;
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_ready_accept got=%b exp=1", rdy); end
    tick();
    data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      $display("b2b sym%0d enc=%b ev=%b rdy=%b", i, enc, ev, rdy);
      checks++; if (enc !== exp_s[i]) begin failures++; $display("FAIL b2b_sym%0d got=%b exp=%b", i, enc, exp_s[i]); end
      checks++; if (ev !== 1'b1) begin failures++; $display("FAIL b2b_ev%0d got=%b exp=1", i, ev); end
      if (i < 7) begin
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=0", i, rdy); end
      end else if (i == 7) begin
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_ready_last got=%b exp=1", rdy); end
      end
      if (i == 8) dv = 1'b0;
      tick();
    end
    checks++; if (ev !== 1'b0) begin failures++; $display("FAIL b2b_idle_ev got=%b exp=0", ev); end
    checks++; if (wc !== 16'd2) begin failures++; $display("FAIL b2b_wc got=%0d exp=2", wc); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    dv = 1'b1; data = 8'hE0; mode = 2'd0;
    tick();
    dv = 1'b0;
    repeat (2) tick();
    // three CMI symbols shown (11,00,11): flag is 1 at this point
    rst = 1'b1;
    #1;
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", rdy); end
    tick();
    rst = 1'b0;
    $display("midrst enc=%b ev=%b wc=%0d", enc, ev, wc);
    checks++; if (enc !== 2'b01) begin failures++; $display("FAIL midrst_enc got=%b exp=01", enc); end
    checks++; if (ev !== 1'b0) begin failures++; $display("FAIL midrst_ev got=%b exp=0", ev); end
    checks++; if (wc !== 16'd0) begin failures++; $display("FAIL midrst_wc got=%0d exp=0", wc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    dv = 1'b1; data = 8'h80;
    tick();
    dv = 1'b0;
    checks++; if (enc !== 2'b11) begin failures++; $display("FAIL midrst_80_first got=%b exp=11", enc); end
    repeat (8) tick();
  endtask

  task automatic test_mode_change();
    logic [1:0] exp_s [16] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00,
                               2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    do_reset();
    dv = 1'b1; data = 8'hFF; mode = 2'd0;
    tick();
    dv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      $display("modechg sym%0d enc=%b", i, enc);
      checks++; if (enc !== exp_s[i]) begin failures++; $display("FAIL modechg_sym%0d got=%b exp=%b", i, enc, exp_s[i]); end
      if (i == 3) mode = 2'd1;
      if (i == 7) begin dv = 1'b1; data = 8'hF0; end
      if (i == 8) dv = 1'b0;
      tick();
    end
    checks++; if (ev !== 1'b0) begin failures++; $display("FAIL modechg_idle_ev got=%b exp=0", ev); end
  endtask

  task automatic test_lsb_first();
    rst1 = 1'b1; dv1 = 1'b0; mode1 = 2'd3; data1 = 8'h00;
    tick();
    rst1 = 1'b0;
    dv1 = 1'b1; data1 = 8'h01;
    tick();
    dv1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      $display("lsb 01 sym%0d enc=%b", i, enc1);
      if (i == 0) begin
        checks++; if (enc1 !== 2'b11) begin failures++; $display("FAIL lsb_sym0 got=%b exp=11", enc1); end
      end else begin
        checks++; if (enc1 !== 2'b00) begin failures++; $display("FAIL lsb_sym%0d got=%b exp=00", i, enc1); end
      end
      tick();
    end
    checks++; if (ev1 !== 1'b0) begin failures++; $display("FAIL lsb_idle_ev got=%b exp=0", ev1); end
  endtask

  task automatic test_width1();
    // INIT_POL=1: first CMI one is 00, then alternation continues
    logic [1:0] exp_s [4] = '{2'b00, 2'b11, 2'b01, 2'b00};
    logic       bits  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    rst2 = 1'b1; dv2 = 1'b0; mode2 = 2'd0; data2 = 1'b0;
    tick();
    rst2 = 1'b0;
    dv2 = 1'b1; data2 = bits[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      $display("w1 sym%0d enc=%b rdy=%b", i, enc2, rdy2);
      checks++; if (enc2 !== exp_s[i]) begin failures++; $display("FAIL w1_sym%0d got=%b exp=%b", i, enc2, exp_s[i]); end
      checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL w1_ready%0d got=%b exp=1", i, rdy2); end
      if (i < 3) data2 = bits[i+1]; else dv2 = 1'b0;
      tick();
    end
    checks++; if (ev2 !== 1'b0) begin failures++; $display("FAIL w1_idle_ev got=%b exp=0", ev2); end
    checks++; if (wc2 !== 16'd4) begin failures++; $display("FAIL w1_wc got=%0d exp=4", wc2); end
  endtask

  initial begin
    rst = 1'b1;  dv = 1'b0;  mode = 2'd0;  data = 8'h00;
    rst1 = 1'b1; dv1 = 1'b0; mode1 = 2'd0; data1 = 8'h00;
    rst2 = 1'b1; dv2 = 1'b0; mode2 = 2'd0; data2 = 1'b0;
    test_reset();
    test_cmi();
    test_manchester();
    test_diff_manchester();
    test_back_to_back();
    test_reset_mid_word();
    test_mode_change();
    test_lsb_first();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
